// File: rtl/reg_file_seq_init.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_seq_init
// Description : Parametrised register file with NUM_RD combinational read
//               ports, one synchronous write port, an optional hard-wired
//               zero register, optional write-to-read bypass and a sequential
//               initialisation engine. After reset, or after a reinit pulse,
//               the engine loads one register per cycle from an external
//               image ROM through init_addr/init_data.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1               rising-edge clock
//   rst        in   1               asynchronous active-low reset
//   reinit     in   1               restart the initialisation sequence
//   init_addr  out  ADDR_W          register index being loaded (0 in RUN)
//   init_data  in   DATA_W          image word for init_addr, same cycle
//   ready      out  1               file initialised, writes accepted
//   we         in   1               write enable
//   waddr      in   ADDR_W          write address
//   wdata      in   DATA_W          write data
//   raddr      in   NUM_RD*ADDR_W   packed read addresses, port k at
//                                   [k*ADDR_W +: ADDR_W]
//   rdata      out  NUM_RD*DATA_W   packed read data, same packing
// ============================================================================
module reg_file_seq_init #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reinit,
    output logic [ADDR_W-1:0]        init_addr,
    input  logic [DATA_W-1:0]        init_data,
    output logic                     ready,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata
);

    localparam int              NUM_REGS   = 2 ** ADDR_W;
    // Counter is one bit wider than the address so NUM_REGS is representable.
    localparam logic [ADDR_W:0] c_LAST_IDX = (ADDR_W + 1)'(NUM_REGS - 1);
    localparam logic [ADDR_W:0] c_CNT_ONE  = (ADDR_W + 1)'(1);
    localparam bit              c_ZERO_EN  = (ZERO_REG != 0);
    localparam bit              c_BYP_EN   = (BYPASS != 0);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    logic              w_wr_ok;
    logic              w_init_zero;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic. reinit overrides everything, including the
    // final INIT step, so a pulse on that edge still restarts from index 0.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (reinit) begin
            state_d = ST_INIT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (cnt_q == c_LAST_IDX) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + c_CNT_ONE;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs. ready is a pure decode of the state register, so it is
    // low for every cycle in which init_data is being consumed.
    // ------------------------------------------------------------------------
    always_comb begin
        ready     = 1'b0;
        init_addr = '0;
        case (state_q)
            ST_INIT: init_addr = cnt_q[ADDR_W-1:0];
            ST_RUN:  ready     = 1'b1;
            default: begin
                ready     = 1'b0;
                init_addr = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Write port arbitration
    // ------------------------------------------------------------------------
    // A user write survives only in RUN, without a concurrent reinit, and
    // not to the hard-wired zero register. The same term qualifies bypass.
    assign w_wr_ok = (state_q == ST_RUN) && we && !reinit &&
                     !(c_ZERO_EN && (waddr == '0));

    assign w_init_zero = c_ZERO_EN && (cnt_q == '0);

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = waddr;
        w_mem_wdata = wdata;
        // Held-in-reset cycles must not touch the array: its contents are
        // deliberately preserved across reset.
        if (rst && !reinit) begin
            if (state_q == ST_INIT) begin
                w_mem_we    = 1'b1;
                w_mem_addr  = cnt_q[ADDR_W-1:0];
                w_mem_wdata = w_init_zero ? '0 : init_data;
            end else if (w_wr_ok) begin
                w_mem_we = 1'b1;
            end
        end
    end

    // Storage array: no reset, contents persist until reloaded.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_mem_addr] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Read ports: fully independent combinational lookups
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_rd;

        assign w_ra = raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            if (!ready) begin
                w_rd = '0;
            end else if (c_ZERO_EN && (w_ra == '0)) begin
                w_rd = '0;
            end else if (c_BYP_EN && w_wr_ok && (waddr == w_ra)) begin
                w_rd = wdata;
            end else begin
                w_rd = mem_q[w_ra];
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = w_rd;
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_seq_init.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_reg_file_seq_init
// Description : Self-checking bench for reg_file_seq_init. Three instances:
//               u0 defaults (ZERO_REG=1, BYPASS=1), u1 (ZERO_REG=0, BYPASS=0)
//               sharing u0's stimulus, and u2 (NUM_RD=4, DATA_W=16, ADDR_W=3).
//               Expected read data is queued when stimulus is applied and
//               popped against the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_seq_init;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        reinit;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [31:0] base;

    logic [4:0]  init_addr0, init_addr1;
    logic [31:0] init_data0, init_data1;
    logic        ready0, ready1;
    logic [63:0] rdata0, rdata1;

    logic        reinit2;
    logic        we2;
    logic [2:0]  waddr2;
    logic [15:0] wdata2;
    logic [11:0] raddr2;
    logic [2:0]  init_addr2;
    logic [15:0] init_data2;
    logic        ready2;
    logic [63:0] rdata2;

    // Image ROMs
    assign init_data0 = base + {27'd0, init_addr0};
    assign init_data1 = base + {27'd0, init_addr1};
    assign init_data2 = 16'h0A00 + {13'd0, init_addr2};

    reg_file_seq_init u0 (
        .clk(clk), .rst(rst), .reinit(reinit), .init_addr(init_addr0),
        .init_data(init_data0), .ready(ready0), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr(raddr), .rdata(rdata0)
    );

    reg_file_seq_init #(.ZERO_REG(0), .BYPASS(0)) u1 (
        .clk(clk), .rst(rst), .reinit(reinit), .init_addr(init_addr1),
        .init_data(init_data1), .ready(ready1), .we(we), .waddr(waddr),
        .wdata(wdata), .raddr(raddr), .rdata(rdata1)
    );

    reg_file_seq_init #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) u2 (
        .clk(clk), .rst(rst), .reinit(reinit2), .init_addr(init_addr2),
        .init_data(init_data2), .ready(ready2), .we(we2), .waddr(waddr2),
        .wdata(wdata2), .raddr(raddr2), .rdata(rdata2)
    );

    typedef struct {
        int          dut;
        int          port;
        logic [31:0] exp;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    function automatic logic [31:0] get_rdata(int dut, int port);
        case (dut)
            0:       return rdata0[port*32 +: 32];
            1:       return rdata1[port*32 +: 32];
            default: return {16'd0, rdata2[port*16 +: 16]};
        endcase
    endfunction

    task automatic push(int dut, int port, logic [31:0] exp);
        sb_t e;
        e.dut  = dut;
        e.port = port;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        sb_t         e;
        logic [31:0] act;
        rst = 1'b0; reinit = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        raddr = {5'd5, 5'd3}; base = 32'hA000_0000;
        reinit2 = 1'b0; we2 = 1'b0; waddr2 = '0; wdata2 = '0;
        raddr2 = {3'd4, 3'd3, 3'd2, 3'd1};
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({ready0, ready1, ready2} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 000", {ready0, ready1, ready2});
        end
        checks++;
        if (init_addr0 !== 5'd0 || init_addr2 !== 3'd0) begin
            errors++;
            $display("FAIL reset_init_addr: got %0d/%0d expected 0/0", init_addr0, init_addr2);
        end
        for (int p = 0; p < 2; p++) begin
            push(0, p, 32'd0);
            push(1, p, 32'd0);
        end
        for (int p = 0; p < 4; p++) push(2, p, 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = get_rdata(e.dut, e.port);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL reset_rdata dut%0d port%0d: got %h expected %h", e.dut, e.port, act, e.exp);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_init();
        sb_t         e;
        logic [31:0] act;
        int          n0, n1, n2;
        @(negedge clk);
        rst = 1'b1;
        n0 = 0; n1 = 0; n2 = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 10) begin
                checks++;
                if (init_addr0 !== 5'd10) begin
                    errors++;
                    $display("FAIL init_addr_at_10: got %0d expected 10", init_addr0);
                end
            end
            if (ready0 && n0 == 0) n0 = i;
            if (ready1 && n1 == 0) n1 = i;
            if (ready2 && n2 == 0) n2 = i;
            if (n0 != 0 && n1 != 0 && n2 != 0) break;
        end
        checks++;
        if (n0 != 32 || n1 != 32) begin
            errors++;
            $display("FAIL init_latency32: got %0d/%0d expected 32", n0, n1);
        end
        checks++;
        if (n2 != 8) begin
            errors++;
            $display("FAIL init_latency8: got %0d expected 8", n2);
        end
        @(negedge clk);
        raddr = {5'd5, 5'd0};
        #1;
        push(0, 0, 32'h0);          push(0, 1, 32'hA000_0005);
        push(1, 0, 32'hA000_0000);  push(1, 1, 32'hA000_0005);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = get_rdata(e.dut, e.port);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL init_read_0_5 dut%0d port%0d: got %h expected %h", e.dut, e.port, act, e.exp);
            end
        end
        raddr = {5'd5, 5'd31};
        #1;
        push(0, 0, 32'hA000_001F);  push(1, 0, 32'hA000_001F);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = get_rdata(e.dut, e.port);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL init_read_31 dut%0d port%0d: got %h expected %h", e.dut, e.port, act, e.exp);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_bypass();
        sb_t         e;
        logic [31:0] act;
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF; raddr = {5'd7, 5'd7};
        #1;
        for (int p = 0; p < 2; p++) begin
            push(0, p, 32'hDEAD_BEEF);
            push(1, p, 32'hA000_0007);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = get_rdata(e.dut, e.port);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL bypass_write_cycle dut%0d port%0d: got %h expected %h", e.dut, e.port, act, e.exp);
            end
        end
        // Back-to-back writes to reg10 and reg11 follow the reg7 write.
        @(negedge clk);
        waddr = 5'd10; wdata = 32'h0000_0A0A;
        @(negedge clk);
        waddr = 5'd11; wdata = 32'h0000_0B0B;
        @(negedge clk);
        we = 1'b0;
        #1;
        for (int p = 0; p < 2; p++) begin
            push(0, p, 32'hDEAD_BEEF);
            push(1, p, 32'hDEAD_BEEF);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = get_rdata(e.dut, e.port);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL bypass_after_write dut%0d port%0d: got %h expected %h", e.dut, e.port, act, e.exp);
            end
        end
        raddr = {5'd11, 5'd10};
        #1;
        push(0, 0, 32'h0000_0A0A);  push(0, 1, 32'h0000_0B0B);
        push(1, 0, 32'h0000_0A0A);  push(1, 1, 32'h0000_0B0B);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = get_rdata(e.dut, e.port);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL back_to_back dut%0d port%0d: got %h expected %h", e.dut, e.port, act, e.exp);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_zero_reg();
        sb_t         e;
        logic [31:0] act;
        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 32'h0000_1234; raddr = {5'd0, 5'd0};
        #1;
        for (int p = 0; p < 2; p++) begin
            push(0, p, 32'h0);
            push(1, p, 32'hA000_0000);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = get_rdata(e.dut, e.port);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL zero_write_cycle dut%0d port%0d: got %h expected %h", e.dut, e.port, act, e.exp);
            end
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        for (int p = 0; p < 2; p++) begin
            push(0, p, 32'h0);
            push(1, p, 32'h0000_1234);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = get_rdata(e.dut, e.port);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL zero_after_write dut%0d port%0d: got %h expected %h", e.dut, e.port, act, e.exp);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reinit();
        sb_t         e;
        logic [31:0] act;
        int          n0, n1;
        @(negedge clk);
        reinit = 1'b1; we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0055;
        raddr = {5'd3, 5'd3};
        #1;
        // reinit suppresses the write, so no bypass in this cycle either.
        for (int p = 0; p < 2; p++) begin
            push(0, p, 32'hA000_0003);
            push(1, p, 32'hA000_0003);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = get_rdata(e.dut, e.port);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL reinit_cycle dut%0d port%0d: got %h expected %h", e.dut, e.port, act, e.exp);
            end
        end
        @(posedge clk);
        #1;
        reinit = 1'b0; we = 1'b0;
        #1;
        checks++;
        if (ready0 !== 1'b0 || ready1 !== 1'b0) begin
            errors++;
            $display("FAIL reinit_ready_drop: got %b%b expected 00", ready0, ready1);
        end
        checks++;
        if (rdata0 !== 64'd0) begin
            errors++;
            $display("FAIL reinit_rdata_zero: got %h expected 0", rdata0);
        end
        n0 = 0; n1 = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ready0 && n0 == 0) n0 = i;
            if (ready1 && n1 == 0) n1 = i;
            if (n0 != 0 && n1 != 0) break;
        end
        checks++;
        if (n0 != 32 || n1 != 32) begin
            errors++;
            $display("FAIL reinit_latency: got %0d/%0d expected 32", n0, n1);
        end
        @(negedge clk);
        raddr = {5'd7, 5'd3};
        #1;
        push(0, 0, 32'hA000_0003);  push(0, 1, 32'hA000_0007);
        push(1, 0, 32'hA000_0003);  push(1, 1, 32'hA000_0007);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = get_rdata(e.dut, e.port);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL reinit_reload dut%0d port%0d: got %h expected %h", e.dut, e.port, act, e.exp);
            end
        end
        raddr = {5'd0, 5'd0};
        #1;
        push(1, 0, 32'hA000_0000);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = get_rdata(e.dut, e.port);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL reinit_reg0_reload dut%0d port%0d: got %h expected %h", e.dut, e.port, act, e.exp);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_rst_mid_init();
        sb_t         e;
        logic [31:0] act;
        int          n0, n2;
        bit          found;
        @(negedge clk);
        reinit = 1'b1;
        @(posedge clk);
        #1;
        reinit = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (init_addr0 == 5'd10) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL reach_index10: got %0d expected 10", init_addr0);
        end
        rst = 1'b0;
        raddr = {5'd9, 5'd31};
        #1;
        checks++;
        if ({ready0, ready1, ready2} !== 3'b000 || init_addr0 !== 5'd0) begin
            errors++;
            $display("FAIL rst_mid_state: got ready=%b init_addr=%0d expected 000/0",
                     {ready0, ready1, ready2}, init_addr0);
        end
        push(0, 0, 32'h0); push(0, 1, 32'h0); push(1, 0, 32'h0); push(1, 1, 32'h0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = get_rdata(e.dut, e.port);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL rst_mid_rdata dut%0d port%0d: got %h expected %h", e.dut, e.port, act, e.exp);
            end
        end
        base = 32'hB000_0000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n0 = 0; n2 = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ready0 && n0 == 0) n0 = i;
            if (ready2 && n2 == 0) n2 = i;
            if (n0 != 0 && n2 != 0) break;
        end
        checks++;
        if (n0 != 32 || n2 != 8) begin
            errors++;
            $display("FAIL rst_reload_latency: got %0d/%0d expected 32/8", n0, n2);
        end
        @(negedge clk);
        #1;
        push(0, 0, 32'hB000_001F);  push(0, 1, 32'hB000_0009);
        push(1, 0, 32'hB000_001F);  push(1, 1, 32'hB000_0009);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = get_rdata(e.dut, e.port);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL rst_reload_read dut%0d port%0d: got %h expected %h", e.dut, e.port, act, e.exp);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_multiport();
        sb_t         e;
        logic [31:0] act;
        @(negedge clk);
        raddr2 = {3'd4, 3'd3, 3'd2, 3'd1};
        #1;
        for (int p = 0; p < 4; p++) push(2, p, 32'h0A01 + p);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = get_rdata(e.dut, e.port);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL multiport_distinct port%0d: got %h expected %h", e.port, act, e.exp);
            end
        end
        raddr2 = {3'd5, 3'd5, 3'd5, 3'd5};
        #1;
        for (int p = 0; p < 4; p++) push(2, p, 32'h0A05);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = get_rdata(e.dut, e.port);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL multiport_same port%0d: got %h expected %h", e.port, act, e.exp);
            end
        end
        @(negedge clk);
        we2 = 1'b1; waddr2 = 3'd2; wdata2 = 16'h1BCD;
        raddr2 = {3'd2, 3'd7, 3'd2, 3'd0};
        #1;
        push(2, 0, 32'h0);    push(2, 1, 32'h1BCD);
        push(2, 2, 32'h0A07); push(2, 3, 32'h1BCD);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = get_rdata(e.dut, e.port);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL multiport_bypass port%0d: got %h expected %h", e.port, act, e.exp);
            end
        end
        @(negedge clk);
        we2 = 1'b0;
        #1;
        push(2, 1, 32'h1BCD);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = get_rdata(e.dut, e.port);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL multiport_after_write port%0d: got %h expected %h", e.port, act, e.exp);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    initial begin
        test_reset();
        test_init();
        test_bypass();
        test_zero_reg();
        test_reinit();
        test_rst_mid_init();
        test_multiport();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
